instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Sequential front end that owns the program counter, fetches 32-bit instructions from instruction memory over a req/ack handshake, and presents the opcode field to the control unit. It consumes the control unit's jump (active-low) and branch outputs plus the ALU zero flag, and computes the next PC. The block sits between instruction memory and the decode/control path of the single-cycle core.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] are forced to 0 internally.
TIMEOUT, 15, maximum FETCH cycles without imem_ack before fetch_err (only with FETCH_TIMEOUT_EN).

Ports:
clk  input  1  system clock, all state updates on the rising edge
rst  input  1  synchronous reset, active-high
imem_req  output  1  fetch request, held high in FETCH
imem_addr  output  32  fetch address, equals pc while imem_req=1
imem_ack  input  1  memory returns data this cycle on imem_rdata
imem_rdata  input  32  instruction word
instr  output  32  latched instruction
op  output  6  instr[31:26], drives the control unit op input
instr_valid  output  1  instr/op valid for the core
advance  input  1  core has finished the current instruction
jump  input  1  from control unit, ACTIVE-LOW: 0 selects jump target
branch  input  1  from control unit, 1 = conditional branch
zero  input  1  ALU zero flag
pc  output  32  current PC
fetch_err  output  1  sticky fetch timeout flag (0 when feature compiled out)

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst.
- Reset values: pc=RESET_PC&~3, instr=0, instr_valid=0, imem_req=0, fetch_err=0, state=IDLE.
- FSM states: IDLE, FETCH, EXEC.
- IDLE: unconditional move to FETCH next cycle, so imem_req rises on the first edge after rst deasserts.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack=1: instr<=imem_rdata, instr_valid<=1, go to EXEC. Ack latency from memory is unbounded unless the feature is enabled.
- EXEC: imem_req=0, and instr/op are held stable. On advance=1: pc<=next_pc, instr_valid<=0, go to FETCH. jump, branch and zero are sampled in the advance cycle only.
- next_pc priority:
  - jump==0: {pc4[31:28], instr[25:0], 2'b00}
  - else branch==1 and zero==1: pc4 + (sign_extend(instr[15:0]) << 2)
  - else: pc4
  - where pc4 = pc + 4.
- Only jump==1'b0 selects the jump target; 1 or X is treated as sequential. Only branch==1'b1 counts as a branch. An undefined opcode therefore falls through to pc4.
- Arithmetic is 32-bit modulo 2^32. pc=32'hFFFF_FFFC with sequential flow gives 0. Branch overflow/underflow wraps without any error.
- advance is ignored outside EXEC. imem_ack is ignored outside FETCH, including a stale ack after reset.
- Reset during FETCH: imem_req is 0 on the next cycle, and any in-flight ack is discarded.
- Reset during EXEC: instr_valid drops and pc reloads to RESET_PC.
- Minimum cycles per instruction is 2 (FETCH with same-cycle ack, then EXEC with advance).

Optional Feature:
FETCH_TIMEOUT_EN
- Defined: a counter clears on entry to FETCH and increments each FETCH cycle without ack. When it reaches TIMEOUT: fetch_err<=1 (sticky until rst), imem_req drops, and the FSM goes to IDLE, which retries at the same pc.
- Not defined: no counter; fetch_err is tied to 0 and FETCH waits indefinitely.

Test Plan:
- Reset release, RESET_PC=0 -> imem_req=1 and imem_addr=0 on cycle 1. Ack with 32'h8C01_0004 -> instr_valid=1 next cycle, op=6'b100011.
- Sequential: advance with jump=1, branch=0 at pc=0x10 -> next imem_addr=0x14.
- Jump: instr=32'hEC00_0040, jump=0, pc=0x20 -> next pc=0x100. Same cycle with branch=1 and zero=1 -> jump still wins, pc=0x100.
- Branch: instr imm=16'hFFFE, branch=1, pc=0x40. zero=1 -> pc=0x3C; zero=0 -> pc=0x44.
- Wrap and reset mid-op: pc=0xFFFF_FFFC sequential -> pc=0. rst during FETCH with ack on the next cycle -> instr unchanged (0), instr_valid=0.
- FETCH_TIMEOUT_EN, TIMEOUT=15, ack withheld -> fetch_err=1 after 15 FETCH cycles and a retry at the same pc. Ack then accepted -> fetch_err stays 1.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, imem req/ack handshake, next-PC select.
// Define FETCH_TIMEOUT_EN to add the sticky fetch_err ack-timeout watchdog.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic        instr_valid,
  input  logic        advance,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] pc,
  output logic        fetch_err
);

  localparam logic [31:0] PC0 = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        take_ack;
  logic        take_adv;
  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] pc_nx;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt;
  logic          tmo;
`endif

  assign imem_addr = pc;
  assign op        = instr[31:26];

  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    take_ack = 1'b0;
    take_adv = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    tmo      = 1'b0;
`endif
    unique case (state)
      IDLE: state_nx = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          take_ack = 1'b1;
          state_nx = EXEC;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt == LAST) begin
          tmo      = 1'b1;
          state_nx = IDLE;
        end
`endif
      end
      EXEC: begin
        if (advance) begin
          take_adv = 1'b1;
          state_nx = FETCH;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Only a clean 0 on jump / 1 on branch redirects; anything else is sequential.
  always_comb begin
    pc4    = pc + 32'd4;
    br_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    if (!jump)
      pc_nx = {pc4[31:28], instr[25:0], 2'b00};
    else if (branch && zero)
      pc_nx = pc4 + br_off;
    else
      pc_nx = pc4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= PC0;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
    end else begin
      state <= state_nx;
      if (take_ack) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (take_adv) begin
        pc          <= pc_nx;
        instr_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Counter is held at zero outside FETCH, so it restarts on every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (state != FETCH)
        cnt <= '0;
      else if (!imem_ack && !tmo)
        cnt <= cnt + CW'(1);
      if (tmo)
        fetch_err <= 1'b1;
    end
  end
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit.
// Random programs are checked against an arithmetic next-PC model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic        instr_valid;
  logic        advance;
  logic        jump;
  logic        branch;
  logic        zero;
  logic [31:0] pc;
  logic        fetch_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mpc;

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .TIMEOUT (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .op         (op),
    .instr_valid(instr_valid),
    .advance    (advance),
    .jump       (jump),
    .branch     (branch),
    .zero       (zero),
    .pc         (pc),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_next(
    input logic [31:0] p,
    input logic [31:0] w,
    input logic        j,
    input logic        b,
    input logic        z
  );
    logic [31:0] s;
    s = p + 32'd4;
    if (j == 1'b0)
      return (s & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (b && z)
      return s + 32'($signed(w[15:0]) * 4);
    return s;
  endfunction

  task automatic run_instr(
    input  logic [31:0] w,
    input  int          dly,
    input  int          hold,
    input  logic        j,
    input  logic        b,
    input  logic        z,
    output logic [31:0] addr,
    output logic        v,
    output logic [5:0]  o,
    output logic [31:0] iw,
    output logic        rq
  );
    int n;
    n = 0;
    while (!imem_req && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!imem_req) begin
      checks++;
      errors++;
      $display("FAIL req_wait: imem_req=%b required 1", imem_req);
    end
    addr = imem_addr;
    repeat (dly) begin
      advance = 1'($urandom);
      @(posedge clk); #1;
    end
    advance    = 1'b0;
    imem_rdata = w;
    imem_ack   = 1'b1;
    @(posedge clk); #1;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    repeat (hold) begin
      imem_ack = 1'($urandom);
      jump     = 1'($urandom);
      branch   = 1'($urandom);
      zero     = 1'($urandom);
      @(posedge clk); #1;
    end
    imem_ack = 1'b0;
    v  = instr_valid;
    o  = op;
    iw = instr;
    rq = imem_req;
    jump    = j;
    branch  = b;
    zero    = z;
    advance = 1'b1;
    @(posedge clk); #1;
    advance = 1'b0;
    jump    = 1'b1;
    branch  = 1'b0;
    zero    = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] a, iw;
    logic        v, rq;
    logic [5:0]  o;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    advance = 1'b0; jump = 1'b1; branch = 1'b0; zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pc !== 32'h0) begin
      errors++; $display("FAIL rst_pc: got %h want 0", pc);
    end
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_ctl: valid=%b req=%b want 0 0", instr_valid, imem_req);
    end
    checks++;
    if (instr !== 32'h0 || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_instr: instr=%h err=%b want 0 0", instr, fetch_err);
    end
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h want 1 0", imem_req, imem_addr);
    end
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0) begin
      errors++;
      $display("FAIL stale_ack: valid=%b instr=%h want 0 0", instr_valid, instr);
    end
    mpc = 32'h0;
    run_instr(32'h8C01_0004, 0, 0, 1'b1, 1'b0, 1'b0, a, v, o, iw, rq);
    checks++;
    if (v !== 1'b1 || o !== 6'b100011) begin
      errors++;
      $display("FAIL first_op: valid=%b op=%b want 1 100011", v, o);
    end
    mpc = ref_next(mpc, 32'h8C01_0004, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pc !== mpc) begin
      errors++; $display("FAIL first_pc: got %h want %h", pc, mpc);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] a, iw, w;
    logic        v, rq;
    logic [5:0]  o;
    for (int i = 0; i < 8 && mpc != 32'h10; i++) begin
      w = $urandom;
      run_instr(w, 1, 0, 1'b1, 1'b0, 1'($urandom), a, v, o, iw, rq);
      mpc = ref_next(mpc, w, 1'b1, 1'b0, 1'b0);
    end
    run_instr($urandom, 0, 1, 1'b1, 1'b0, 1'b1, a, v, o, iw, rq);
    checks++;
    if (a !== 32'h10) begin
      errors++; $display("FAIL seq_from: addr=%h want 10", a);
    end
    checks++;
    if (imem_addr !== 32'h14 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL seq_next: addr=%h req=%b want 14 1", imem_addr, imem_req);
    end
    mpc = 32'h14;
  endtask

  task automatic test_jump();
    logic [31:0] a, iw;
    logic        v, rq;
    logic [5:0]  o;
    run_instr(32'hEC00_0008, 0, 0, 1'b0, 1'b0, 1'b0, a, v, o, iw, rq);
    checks++;
    if (pc !== 32'h20) begin
      errors++; $display("FAIL jmp_to20: pc=%h want 20", pc);
    end
    run_instr(32'hEC00_0040, 2, 1, 1'b0, 1'b0, 1'b0, a, v, o, iw, rq);
    checks++;
    if (pc !== 32'h100) begin
      errors++; $display("FAIL jmp_plain: pc=%h want 100", pc);
    end
    run_instr(32'hEC00_0008, 0, 0, 1'b0, 1'b0, 1'b0, a, v, o, iw, rq);
    run_instr(32'hEC00_0040, 0, 0, 1'b0, 1'b1, 1'b1, a, v, o, iw, rq);
    checks++;
    if (pc !== 32'h100) begin
      errors++; $display("FAIL jmp_over_br: pc=%h want 100", pc);
    end
    mpc = 32'h100;
  endtask

  task automatic test_branch();
    logic [31:0] a, iw;
    logic        v, rq;
    logic [5:0]  o;
    run_instr(32'hEC00_0010, 0, 0, 1'b0, 1'b0, 1'b0, a, v, o, iw, rq);
    run_instr(32'h1000_FFFE, 1, 0, 1'b1, 1'b1, 1'b1, a, v, o, iw, rq);
    checks++;
    if (pc !== 32'h3C) begin
      errors++; $display("FAIL br_taken: pc=%h want 3c", pc);
    end
    run_instr(32'hEC00_0010, 0, 0, 1'b0, 1'b0, 1'b0, a, v, o, iw, rq);
    run_instr(32'h1000_FFFE, 0, 2, 1'b1, 1'b1, 1'b0, a, v, o, iw, rq);
    checks++;
    if (pc !== 32'h44) begin
      errors++; $display("FAIL br_not_taken: pc=%h want 44", pc);
    end
    mpc = 32'h44;
  endtask

  task automatic test_wrap();
    logic [31:0] a, iw;
    logic        v, rq;
    logic [5:0]  o;
    run_instr(32'hEC00_0000, 0, 0, 1'b0, 1'b0, 1'b0, a, v, o, iw, rq);
    run_instr(32'h1000_FFFE, 0, 0, 1'b1, 1'b1, 1'b1, a, v, o, iw, rq);
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL br_underflow: pc=%h want fffffffc", pc);
    end
    run_instr($urandom, 0, 0, 1'b1, 1'b0, 1'b0, a, v, o, iw, rq);
    checks++;
    if (a !== 32'hFFFF_FFFC || pc !== 32'h0) begin
      errors++; $display("FAIL pc_wrap: from=%h pc=%h want fffffffc 0", a, pc);
    end
    mpc = 32'h0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, iw;
    logic        v, rq;
    logic [5:0]  o;
    run_instr($urandom, 0, 0, 1'b1, 1'b0, 1'b0, a, v, o, iw, rq);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (imem_req !== 1'b0 || pc !== 32'h0) begin
      errors++;
      $display("FAIL rst_fetch: req=%b pc=%h want 0 0", imem_req, pc);
    end
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hA5A5_5A5B;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    checks++;
    if (instr !== 32'h0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_inflight: instr=%h valid=%b want 0 0", instr, instr_valid);
    end
    run_instr($urandom, 0, 0, 1'b1, 1'b0, 1'b0, a, v, o, iw, rq);
    imem_rdata = 32'h1234_5678; imem_ack = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || pc !== 32'h0) begin
      errors++;
      $display("FAIL rst_exec: valid=%b pc=%h want 0 0", instr_valid, pc);
    end
    mpc = 32'h0;
  endtask

  task automatic test_random();
    logic [31:0] a, iw, w;
    logic        v, rq, j, b, z;
    logic [5:0]  o;
    for (int i = 0; i < 300; i++) begin
      w = $urandom;
      j = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      b = 1'($urandom);
      z = 1'($urandom);
      run_instr(w, $urandom_range(0, 3), $urandom_range(0, 2),
                j, b, z, a, v, o, iw, rq);
      checks++;
      if (a !== mpc) begin
        errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, a, mpc);
      end
      checks++;
      if (v !== 1'b1 || rq !== 1'b0) begin
        errors++;
        $display("FAIL rnd_exec[%0d]: valid=%b req=%b want 1 0", i, v, rq);
      end
      checks++;
      if (iw !== w || o !== w[31:26]) begin
        errors++;
        $display("FAIL rnd_instr[%0d]: got %h/%b want %h", i, iw, o, w);
      end
      mpc = ref_next(mpc, w, j, b, z);
      checks++;
      if (pc !== mpc) begin
        errors++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc, mpc);
      end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] a, iw;
    logic        v, rq;
    logic [5:0]  o;
    rst = 1'b1; imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
        errors++;
        $display("FAIL tmo_wait[%0d]: req=%b err=%b want 1 0", i, imem_req, fetch_err);
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    checks++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL tmo_fire: err=%b req=%b want 1 0", fetch_err, imem_req);
    end
    @(posedge clk); #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL tmo_retry: req=%b addr=%h want 1 0", imem_req, imem_addr);
    end
`else
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL no_tmo: req=%b err=%b want 1 0", imem_req, fetch_err);
    end
`endif
    run_instr(32'h8C01_0004, 0, 0, 1'b1, 1'b0, 1'b0, a, v, o, iw, rq);
    checks++;
    if (v !== 1'b1 || pc !== 32'h4) begin
      errors++; $display("FAIL late_ack: valid=%b pc=%h want 1 4", v, pc);
    end
`ifdef FETCH_TIMEOUT_EN
    checks++;
    if (fetch_err !== 1'b1) begin
      errors++; $display("FAIL tmo_sticky: err=%b want 1", fetch_err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_branch();
    test_wrap();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
